// File: rtl/data_memory_mmio.sv
// data_memory_mmio
//   Byte-addressable data RAM with byte-lane writes, a fixed-latency req/ready
//   handshake, misalignment detection and a small MMIO window (switches, LEDs,
//   debounced button with a sticky press flag).
//
//   clk        system clock, all state on posedge
//   rst        asynchronous active-low reset
//   req        access request, sampled in IDLE only
//   we         1 = store, 0 = load
//   size       0 byte, 1 half, 2 word, 3 illegal
//   sign       sign-extend sub-word loads
//   addr       byte address (addr[31]=1 selects MMIO)
//   wdata      store data, right-aligned
//   ready      one-cycle completion pulse
//   rdata      load result, held until the next completion
//   fault      misaligned/illegal access flag, held with rdata
//   io_switch  switch levels
//   button     raw push-button
//   led        LED register
//
//   state  | meaning
//   IDLE   | waiting for req, request fields latched on accept
//   ACCESS | RAM read issued / store committed / MMIO sampled
//   DONE   | result formatted, ready registered for the next cycle
module data_memory_mmio #(
   parameter int RAM_AW  = 12,
   parameter int SW_W    = 16,
   parameter int LED_W   = 16,
   parameter int DEB_CYC = 100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic             we,
   input  logic [1:0]       size,
   input  logic             sign,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   output logic             ready,
   output logic [31:0]      rdata,
   output logic             fault,
   input  logic [SW_W-1:0]  io_switch,
   input  logic             button,
   output logic [LED_W-1:0] led
);

   localparam int CNT_W = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state;
   logic        l_we;
   logic [1:0]  l_size;
   logic        l_sign;
   logic [31:0] l_addr;
   logic [31:0] l_wdata;
   logic [31:0] led_shadow;
   logic [31:0] mmio_q;
   logic [31:0] ram_q;
   logic [31:0] mem [2**RAM_AW];

   logic             sync1, sync2, deb, flag;
   logic [CNT_W-1:0] cnt;

   logic              misalign;
   logic              is_mmio;
   logic [5:0]        mmio_off;
   logic [3:0]        be;
   logic [31:0]       wd;
   logic [RAM_AW-1:0] ram_idx;
   logic              ram_we;
   logic              led_we;
   logic              btn_clr;
   logic              deb_last;
   logic              deb_rise;
   logic [31:0]       mmio_val;
   logic [31:0]       rd_word;
   logic [31:0]       shifted;
   logic [31:0]       extracted;
   logic              unused_bits;

   assign misalign = (l_size == 2'd3) || (l_size == 2'd1 && l_addr[0]) ||
                     (l_size == 2'd2 && l_addr[1:0] != 2'b00);
   assign is_mmio  = l_addr[31];
   assign mmio_off = l_addr[7:2];
   assign ram_idx  = l_addr[RAM_AW+1:2];
   assign unused_bits = ^{l_addr, led_shadow};

   // Lane enables and lane-replicated store data, shared by RAM and LED shadow.
   always_comb begin
      be = 4'b0000;
      wd = l_wdata;
      case (l_size)
         2'd0: begin
            be = 4'b0001 << l_addr[1:0];
            wd = {4{l_wdata[7:0]}};
         end
         2'd1: begin
            be = l_addr[1] ? 4'b1100 : 4'b0011;
            wd = {2{l_wdata[15:0]}};
         end
         2'd2: be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   assign ram_we  = (state == ACCESS) && l_we && !misalign && !is_mmio;
   assign led_we  = (state == ACCESS) && l_we && !misalign && is_mmio && mmio_off == 6'd1;
   assign btn_clr = (state == ACCESS) && l_we && !misalign && is_mmio && mmio_off == 6'd2 &&
                    be[0] && wd[1];

   always_comb begin
      mmio_val = 32'd0;
      case (mmio_off)
         6'd0: mmio_val = 32'(io_switch);
         6'd1: mmio_val = 32'(led_shadow[LED_W-1:0]);
         6'd2: mmio_val = {30'd0, flag, deb};
         default: mmio_val = 32'd0;
      endcase
   end

   // Aligned accesses only reach here, so one byte-lane shift serves byte and half.
   assign rd_word = is_mmio ? mmio_q : ram_q;
   assign shifted = rd_word >> {l_addr[1:0], 3'b000};

   always_comb begin
      extracted = rd_word;
      case (l_size)
         2'd0: extracted = l_sign ? {{24{shifted[7]}}, shifted[7:0]} : {24'd0, shifted[7:0]};
         2'd1: extracted = l_sign ? {{16{shifted[15]}}, shifted[15:0]} : {16'd0, shifted[15:0]};
         default: extracted = rd_word;
      endcase
   end

   // RAM has no reset; a write only happens while the FSM sits in ACCESS,
   // so an async reset before the ACCESS edge suppresses it.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ram_we && be[i]) mem[ram_idx][8*i +: 8] <= wd[8*i +: 8];
      end
      ram_q <= mem[ram_idx];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         ready      <= 1'b0;
         rdata      <= 32'd0;
         fault      <= 1'b0;
         l_we       <= 1'b0;
         l_size     <= 2'd0;
         l_sign     <= 1'b0;
         l_addr     <= 32'd0;
         l_wdata    <= 32'd0;
         led_shadow <= 32'd0;
         mmio_q     <= 32'd0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  l_we    <= we;
                  l_size  <= size;
                  l_sign  <= sign;
                  l_addr  <= addr;
                  l_wdata <= wdata;
                  state   <= ACCESS;
               end
            end
            ACCESS: begin
               mmio_q <= mmio_val;
               if (led_we) begin
                  for (int i = 0; i < 4; i++) begin
                     if (be[i]) led_shadow[8*i +: 8] <= wd[8*i +: 8];
                  end
               end
               state <= DONE;
            end
            DONE: begin
               ready <= 1'b1;
               fault <= misalign;
               rdata <= (misalign || l_we) ? 32'd0 : extracted;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign led = led_shadow[LED_W-1:0];

   assign deb_last = (cnt == CNT_W'(DEB_CYC - 1));
   assign deb_rise = !deb && sync2 && deb_last;

   // Counter runs only while the synced input disagrees with the debounced level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         deb   <= 1'b0;
         cnt   <= '0;
         flag  <= 1'b0;
      end else begin
         sync1 <= button;
         sync2 <= sync1;
         if (sync2 != deb) begin
            if (deb_last) begin
               deb <= sync2;
               cnt <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
         // a press landing in the same cycle as a clear must not be lost
         if (deb_rise) flag <= 1'b1;
         else if (btn_clr) flag <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_memory_mmio.sv
module tb_data_memory_mmio;
   localparam int RAM_AW    = 6;
   localparam int SW_W      = 16;
   localparam int LED_W     = 16;
   localparam int DEB_CYC   = 4;
   localparam int RAM_BYTES = 4 * (2**RAM_AW);

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req = 1'b0;
   logic             we = 1'b0;
   logic [1:0]       size = 2'd0;
   logic             sign = 1'b0;
   logic [31:0]      addr = 32'd0;
   logic [31:0]      wdata = 32'd0;
   logic             ready;
   logic [31:0]      rdata;
   logic             fault;
   logic [SW_W-1:0]  io_switch = '0;
   logic             button = 1'b0;
   logic [LED_W-1:0] led;

   data_memory_mmio #(
      .RAM_AW(RAM_AW), .SW_W(SW_W), .LED_W(LED_W), .DEB_CYC(DEB_CYC)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign(sign),
      .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .fault(fault),
      .io_switch(io_switch), .button(button), .led(led)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   logic [7:0] mem_m [RAM_BYTES];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic access(input logic we_i, input logic [1:0] size_i, input logic sign_i,
                         input logic [31:0] addr_i, input logic [31:0] wdata_i,
                         output logic [31:0] rd, output logic flt);
      int lat;
      @(negedge clk);
      we = we_i; size = size_i; sign = sign_i; addr = addr_i; wdata = wdata_i; req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      lat = 0;
      for (int i = 1; i <= 8 && lat == 0; i++) begin
         @(posedge clk);
         #1;
         if (ready) lat = i;
      end
      check("latency", lat, 2);
      rd  = rdata;
      flt = fault;
   endtask

   function automatic logic model_fault(input logic [1:0] s, input logic [31:0] a);
      return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] s, input logic sg, input logic [31:0] a);
      int base = int'(a % RAM_BYTES);
      int n = 1 << s;
      logic [31:0] v = 0;
      for (int k = 0; k < n; k++) v = v | (32'(mem_m[base + k]) << (8 * k));
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic model_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
      int base = int'(a % RAM_BYTES);
      int n = 1 << s;
      for (int k = 0; k < n; k++) mem_m[base + k] = 8'(d >> (8 * k));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, a, d;
      logic        flt, w, sg, ef;
      logic [1:0]  s;
      int          pulses;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 0);
      check("rst_rdata", rdata, 0);
      check("rst_fault", 32'(fault), 0);
      check("rst_led", 32'(led), 0);
      @(negedge clk) rst = 1'b1;

      for (int i = 0; i < 2**RAM_AW; i++) begin
         access(1'b1, 2'd2, 1'b0, 32'(4 * i), 32'd0, rd, flt);
         model_store(2'd2, 32'(4 * i), 32'd0);
      end

      access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, flt);
      model_store(2'd2, 32'h10, 32'hDEADBEEF);
      check("st_word_fault", 32'(flt), 0);
      access(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, flt);
      check("ld_word", rd, 32'hDEADBEEF);
      check("ld_word_fault", 32'(flt), 0);

      access(1'b1, 2'd0, 1'b0, 32'h12, 32'h5A, rd, flt);
      model_store(2'd0, 32'h12, 32'h5A);
      access(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, flt);
      check("ld_after_byte", rd, 32'hDE5ABEEF);
      access(1'b0, 2'd0, 1'b1, 32'h12, 32'd0, rd, flt);
      check("ld_byte_pos", rd, 32'h0000005A);
      access(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, rd, flt);
      check("ld_byte_neg", rd, 32'hFFFFFFDE);
      access(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, rd, flt);
      check("ld_half_zext", rd, 32'h0000DE5A);

      access(1'b0, 2'd1, 1'b0, 32'h11, 32'd0, rd, flt);
      check("mis_half_fault", 32'(flt), 1);
      check("mis_half_rdata", rd, 0);
      access(1'b1, 2'd2, 1'b0, 32'h16, 32'hCAFEF00D, rd, flt);
      check("mis_word_fault", 32'(flt), 1);
      access(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, rd, flt);
      check("mis_no_write", rd, 32'd0);
      access(1'b0, 2'd3, 1'b0, 32'h20, 32'd0, rd, flt);
      check("size3_fault", 32'(flt), 1);
      check("size3_rdata", rd, 0);

      io_switch = 16'hA5C3;
      access(1'b0, 2'd2, 1'b0, 32'h80000000, 32'd0, rd, flt);
      check("sw_read", rd, 32'h0000A5C3);
      access(1'b1, 2'd1, 1'b0, 32'h80000006, 32'h1234, rd, flt);
      check("led_upper", 32'(led), 32'h0000);
      access(1'b1, 2'd1, 1'b0, 32'h80000004, 32'h1234, rd, flt);
      check("led_lower", 32'(led), 32'h1234);
      access(1'b0, 2'd2, 1'b0, 32'h80000004, 32'd0, rd, flt);
      check("led_read", rd, 32'h1234);
      access(1'b0, 2'd2, 1'b0, 32'h80000030, 32'd0, rd, flt);
      check("mmio_other", rd, 32'd0);

      // button glitch shorter than DEB_CYC
      @(negedge clk) button = 1'b1;
      repeat (3) @(posedge clk);
      #1 button = 1'b0;
      repeat (8) @(posedge clk);
      access(1'b0, 2'd2, 1'b0, 32'h80000008, 32'd0, rd, flt);
      check("btn_glitch", rd, 32'h0);
      @(negedge clk) button = 1'b1;
      repeat (10) @(posedge clk);
      access(1'b0, 2'd2, 1'b0, 32'h80000008, 32'd0, rd, flt);
      check("btn_press", rd, 32'h3);
      @(negedge clk) button = 1'b0;
      repeat (10) @(posedge clk);
      access(1'b0, 2'd2, 1'b0, 32'h80000008, 32'd0, rd, flt);
      check("btn_release", rd, 32'h2);
      access(1'b1, 2'd2, 1'b0, 32'h80000008, 32'h2, rd, flt);
      access(1'b0, 2'd2, 1'b0, 32'h80000008, 32'd0, rd, flt);
      check("btn_clear", rd, 32'h0);
      // debounced rise lands on the same edge as the clear write commits
      repeat (10) @(posedge clk);
      @(negedge clk) button = 1'b1;
      repeat (4) @(posedge clk);
      access(1'b1, 2'd2, 1'b0, 32'h80000008, 32'h2, rd, flt);
      access(1'b0, 2'd2, 1'b0, 32'h80000008, 32'd0, rd, flt);
      check("btn_set_wins", rd, 32'h3);
      @(negedge clk) button = 1'b0;
      repeat (10) @(posedge clk);

      for (int i = 0; i < 200; i++) begin
         a  = {1'b0, 31'($urandom)};
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         s  = 2'($urandom_range(0, 3));
         w  = 1'($urandom_range(0, 1));
         sg = 1'($urandom_range(0, 1));
         d  = $urandom;
         ef = model_fault(s, a);
         access(w, s, sg, a, d, rd, flt);
         check("rnd_fault", 32'(flt), 32'(ef));
         if (!ef && w) model_store(s, a, d);
         else if (!w) check("rnd_rdata", rd, ef ? 32'd0 : model_load(s, sg, a));
      end

      for (int i = 0; i < 8; i++) begin
         io_switch = 16'($urandom);
         access(1'b0, 2'd2, 1'b0, 32'h80000000, 32'd0, rd, flt);
         check("rnd_sw", rd, {16'd0, io_switch});
         d = $urandom;
         access(1'b1, 2'd2, 1'b0, 32'h80000004, d, rd, flt);
         check("rnd_led", 32'(led), {16'd0, d[15:0]});
      end

      access(1'b1, 2'd2, 1'b0, 32'h40, 32'h11111111, rd, flt);
      access(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, rd, flt);
      check("pre_rst_ld", rd, 32'h11111111);
      @(negedge clk);
      we = 1'b1; size = 2'd2; sign = 1'b0; addr = 32'h40; wdata = 32'h22222222; req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      #2 rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (ready) pulses++;
      end
      check("abort_no_ready", 32'(pulses), 0);
      check("abort_rdata", rdata, 0);
      check("abort_fault", 32'(fault), 0);
      check("abort_led", 32'(led), 0);
      @(negedge clk) rst = 1'b1;
      access(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, rd, flt);
      check("abort_no_write", rd, 32'h11111111);
      access(1'b0, 2'd2, 1'b0, 32'h80000008, 32'd0, rd, flt);
      check("abort_btn", rd, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
